// File: rtl/axi_rx_toggle_sync.sv
// Toggle-flag synchronizer for axi_rx.
// Turns each flip of the serial-side word flag into a one-cycle aclk pulse.
module axi_rx_toggle_sync (
  input  logic aclk,
  input  logic aresetn,
  input  logic tgl,
  output logic new_word
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= tgl;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign new_word = sync2 ^ prev;

endmodule

// File: rtl/axi_rx.sv
// Serial-to-parallel receiver.
// Captures sclk-strobed words and presents them on a valid/ready port in aclk.
module axi_rx #(
  parameter int packet_length = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     sclk,
  input  logic                     sdata,
  input  logic                     svalid,
  output logic [packet_length-1:0] fifo_data,
  output logic                     fifo_valid,
  input  logic                     fifo_ready
);

  localparam int CW = $clog2(packet_length);
  localparam logic [CW-1:0] LAST = CW'(packet_length - 1);

  logic [packet_length-1:0] shift_reg;
  logic [packet_length-1:0] hold_reg;
  logic [packet_length-1:0] next_shift;
  logic [CW-1:0]            bit_cnt;
  logic                     word_tgl;
  logic                     new_word;

  assign next_shift = {shift_reg[packet_length-2:0], sdata};

  always_ff @(posedge sclk or negedge aresetn) begin
    if (!aresetn) begin
      shift_reg <= '0;
      hold_reg  <= '0;
      bit_cnt   <= '0;
      word_tgl  <= 1'b0;
    end else if (svalid) begin
      shift_reg <= next_shift;
      if (bit_cnt == LAST) begin
        hold_reg <= next_shift;
        word_tgl <= ~word_tgl;
        bit_cnt  <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else begin
      bit_cnt <= '0;
    end
  end

  axi_rx_toggle_sync u_sync (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .tgl      (word_tgl),
    .new_word (new_word)
  );

  // hold_reg is quiet for a whole word time around new_word, so it is safe to sample here.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_data  <= '0;
      fifo_valid <= 1'b0;
    end else if (new_word && (!fifo_valid || fifo_ready)) begin
      fifo_data  <= hold_reg;
      fifo_valid <= 1'b1;
    end else if (fifo_valid && fifo_ready) begin
      fifo_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_rx.sv
// Directed bench for axi_rx.
// Words are sent MSB first on sclk; handshakes are logged from the aclk side.
module tb_axi_rx;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        sclk = 1'b0;
  logic        sdata = 1'b0;
  logic        svalid = 1'b0;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int hi_cnt = 0;
  logic [31:0] rx[$];

  axi_rx #(.packet_length(32)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .sclk       (sclk),
    .sdata      (sdata),
    .svalid     (svalid),
    .fifo_data  (fifo_data),
    .fifo_valid (fifo_valid),
    .fifo_ready (fifo_ready)
  );

  always #5 sclk = ~sclk;
  always #20 aclk = ~aclk;

  always @(negedge aclk) begin
    if (aresetn && fifo_valid) begin
      hi_cnt++;
      if (fifo_ready) rx.push_back(fifo_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] w, input int nbits);
    for (int i = 31; i > 31 - nbits; i--) begin
      @(negedge sclk);
      svalid = 1'b1;
      sdata  = w[i];
    end
    @(negedge sclk);
    svalid = 1'b0;
    sdata  = 1'b0;
  endtask

  task automatic wait_aclk(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge aclk);
    #1;
    fifo_ready = v;
  endtask

  task automatic wait_words(input int n, input string tag);
    int budget;
    budget = 40;
    while (rx.size() < n && budget > 0) begin
      @(posedge aclk);
      budget--;
    end
    #1;
    chk({tag, "_timeout"}, 32'(rx.size() >= n), 32'd1);
  endtask

  initial begin
    int h0;
    #19;
    chk("rst_valid", {31'd0, fifo_valid}, 32'd0);
    chk("rst_data", fifo_data, 32'h0);
    #3 aresetn = 1'b1;

    h0 = hi_cnt;
    send(32'hA5C30F1E, 32);
    wait_words(1, "w1");
    wait_aclk(6);
    chk("w1_count", rx.size(), 1);
    chk("w1_data", rx[0], 32'hA5C30F1E);
    chk("w1_pulse", hi_cnt - h0, 1);
    chk("w1_idle", {31'd0, fifo_valid}, 32'd0);

    #20;
    send(32'h12345678, 32);
    wait_words(2, "w2");
    wait_aclk(6);
    chk("w2_count", rx.size(), 2);
    chk("w2_data", rx[1], 32'h12345678);

    h0 = hi_cnt;
    send(32'hDEADBEEF, 32);
    send(32'h0BADF00D, 32);
    wait_words(4, "b2b");
    wait_aclk(6);
    chk("b2b_count", rx.size(), 4);
    chk("b2b_first", rx[2], 32'hDEADBEEF);
    chk("b2b_second", rx[3], 32'h0BADF00D);
    chk("b2b_pulses", hi_cnt - h0, 2);

    set_ready(1'b0);
    send(32'h11111111, 32);
    wait_aclk(10);
    chk("bp_valid", {31'd0, fifo_valid}, 32'd1);
    chk("bp_data", fifo_data, 32'h11111111);
    send(32'h22222222, 32);
    wait_aclk(10);
    chk("bp_hold_valid", {31'd0, fifo_valid}, 32'd1);
    chk("bp_hold_data", fifo_data, 32'h11111111);
    set_ready(1'b1);
    wait_aclk(4);
    chk("bp_count", rx.size(), 5);
    chk("bp_word", rx[4], 32'h11111111);
    chk("bp_released", {31'd0, fifo_valid}, 32'd0);

    send(32'hFFFFFFFF, 10);
    wait_aclk(6);
    chk("part_none", rx.size(), 5);
    send(32'hCAFEBABE, 32);
    wait_words(6, "part");
    wait_aclk(6);
    chk("part_count", rx.size(), 6);
    chk("part_data", rx[5], 32'hCAFEBABE);

    set_ready(1'b0);
    send(32'h5A5A5A5A, 32);
    wait_aclk(10);
    chk("ar_valid_pre", {31'd0, fifo_valid}, 32'd1);
    #7 aresetn = 1'b0;
    #1;
    chk("ar_valid", {31'd0, fifo_valid}, 32'd0);
    chk("ar_data", fifo_data, 32'h0);
    #30 aresetn = 1'b1;
    set_ready(1'b1);
    wait_aclk(6);
    chk("ar_quiet", {31'd0, fifo_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
